// File: rtl/poly_mult_arbiter.sv
// Two-client arbiter for a shared poly_mult core: round-robin grant, owner-muxed
// core controls, and hold-off of the release while a multiplication is in flight.
//
//   state | meaning
//   IDLE  | no owner; arbitrate on req
//   OWN   | owner drives the core and may start jobs
//   DRAIN | owner released req mid-job; hold grant until pm_valid
//   GAP   | one dead cycle with everything low before re-arbitration
module poly_mult_arbiter #(
    parameter int RAMWIDTH       = 128,
    parameter int M              = 16,
    parameter int LOG_MAX_WEIGHT = 8,
    parameter int RA_W           = 9
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [1:0]                        req,
    output logic [1:0]                        gnt,
    output logic                              busy,
    input  logic [1:0]                        r_start,
    input  logic [2*M-1:0]                    r_loc_in,
    input  logic [2*(LOG_MAX_WEIGHT+1)-1:0]   r_weight,
    input  logic [2*RAMWIDTH-1:0]             r_mux_word_0,
    input  logic [2*RAMWIDTH-1:0]             r_mux_word_1,
    input  logic [1:0]                        r_rd_dout,
    input  logic [2*RA_W-1:0]                 r_addr_result,
    input  logic [1:0]                        r_add_wr_en,
    input  logic [2*RA_W-1:0]                 r_add_addr,
    input  logic [2*RAMWIDTH-1:0]             r_add_in,
    output logic [1:0]                        r_valid,
    output logic                              drop_err,
    output logic                              pm_start,
    output logic [M-1:0]                      pm_loc_in,
    output logic [LOG_MAX_WEIGHT:0]           pm_weight,
    output logic [RAMWIDTH-1:0]               pm_mux_word_0,
    output logic [RAMWIDTH-1:0]               pm_mux_word_1,
    output logic                              pm_rd_dout,
    output logic [RA_W-1:0]                   pm_addr_result,
    output logic                              pm_add_wr_en,
    output logic [RA_W-1:0]                   pm_add_addr,
    output logic [RAMWIDTH-1:0]               pm_add_in,
    input  logic                              pm_valid
);

    localparam int WW = LOG_MAX_WEIGHT + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN   = 2'd1,
        S_DRAIN = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic       job_active_q, job_active_d;
    logic       drop_err_q, drop_err_d;
    logic       winner;
    logic       drive_core;

    // Single requester wins outright; on a tie the client that did not go last wins.
    always_comb begin
        winner = ~last_q;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            default: winner = ~last_q;
        endcase
    end

    assign drive_core = (state_q == S_OWN) || (state_q == S_DRAIN);

    always_comb begin
        pm_start       = 1'b0;
        pm_loc_in      = '0;
        pm_weight      = '0;
        pm_mux_word_0  = '0;
        pm_mux_word_1  = '0;
        pm_rd_dout     = 1'b0;
        pm_addr_result = '0;
        pm_add_wr_en   = 1'b0;
        pm_add_addr    = '0;
        pm_add_in      = '0;
        if (drive_core) begin
            pm_start       = (state_q == S_OWN) && (owner_q ? r_start[1] : r_start[0]);
            pm_loc_in      = owner_q ? r_loc_in[M +: M]               : r_loc_in[0 +: M];
            pm_weight      = owner_q ? r_weight[WW +: WW]             : r_weight[0 +: WW];
            pm_mux_word_0  = owner_q ? r_mux_word_0[RAMWIDTH +: RAMWIDTH] : r_mux_word_0[0 +: RAMWIDTH];
            pm_mux_word_1  = owner_q ? r_mux_word_1[RAMWIDTH +: RAMWIDTH] : r_mux_word_1[0 +: RAMWIDTH];
            pm_rd_dout     = owner_q ? r_rd_dout[1]                   : r_rd_dout[0];
            pm_addr_result = owner_q ? r_addr_result[RA_W +: RA_W]    : r_addr_result[0 +: RA_W];
            pm_add_wr_en   = owner_q ? r_add_wr_en[1]                 : r_add_wr_en[0];
            pm_add_addr    = owner_q ? r_add_addr[RA_W +: RA_W]       : r_add_addr[0 +: RA_W];
            pm_add_in      = owner_q ? r_add_in[RAMWIDTH +: RAMWIDTH] : r_add_in[0 +: RAMWIDTH];
        end
    end

    // A start in the same cycle as pm_valid means a fresh job is in flight.
    always_comb begin
        job_active_d = job_active_q;
        if (pm_start) begin
            job_active_d = 1'b1;
        end else if (pm_valid) begin
            job_active_d = 1'b0;
        end
    end

    assign drop_err_d = drop_err_q | (|(r_start & ~gnt_q));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                gnt_d = 2'b00;
                if (|req) begin
                    owner_d = winner;
                    last_d  = winner;
                    gnt_d   = winner ? 2'b10 : 2'b01;
                    state_d = S_OWN;
                end
            end
            S_OWN: begin
                if (!(owner_q ? req[1] : req[0])) begin
                    if (job_active_d) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_GAP;
                        gnt_d   = 2'b00;
                    end
                end
            end
            S_DRAIN: begin
                if (!job_active_d) begin
                    state_d = S_GAP;
                    gnt_d   = 2'b00;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            gnt_q        <= 2'b00;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            job_active_q <= 1'b0;
            drop_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            job_active_q <= job_active_d;
            drop_err_q   <= drop_err_d;
        end
    end

    assign gnt      = gnt_q;
    assign busy     = drive_core;
    assign r_valid  = {2{pm_valid}} & gnt_q;
    assign drop_err = drop_err_q;

endmodule

// File: tb/tb_poly_mult_arbiter.sv
// Scenario bench for poly_mult_arbiter: grant timing, alternation, drain hold,
// non-owner start flagging, reset mid-drain and owner data muxing.
module tb_poly_mult_arbiter;

    localparam int RAMWIDTH       = 128;
    localparam int M              = 16;
    localparam int LOG_MAX_WEIGHT = 8;
    localparam int RA_W           = 9;
    localparam int WW             = LOG_MAX_WEIGHT + 1;

    logic                  clk;
    logic                  rst;
    logic [1:0]            req;
    logic [1:0]            gnt;
    logic                  busy;
    logic [1:0]            r_start;
    logic [2*M-1:0]        r_loc_in;
    logic [2*WW-1:0]       r_weight;
    logic [2*RAMWIDTH-1:0] r_mux_word_0;
    logic [2*RAMWIDTH-1:0] r_mux_word_1;
    logic [1:0]            r_rd_dout;
    logic [2*RA_W-1:0]     r_addr_result;
    logic [1:0]            r_add_wr_en;
    logic [2*RA_W-1:0]     r_add_addr;
    logic [2*RAMWIDTH-1:0] r_add_in;
    logic [1:0]            r_valid;
    logic                  drop_err;
    logic                  pm_start;
    logic [M-1:0]          pm_loc_in;
    logic [WW-1:0]         pm_weight;
    logic [RAMWIDTH-1:0]   pm_mux_word_0;
    logic [RAMWIDTH-1:0]   pm_mux_word_1;
    logic                  pm_rd_dout;
    logic [RA_W-1:0]       pm_addr_result;
    logic                  pm_add_wr_en;
    logic [RA_W-1:0]       pm_add_addr;
    logic [RAMWIDTH-1:0]   pm_add_in;
    logic                  pm_valid;

    int         n_chk  = 0;
    int         n_pass = 0;
    logic [1:0] sb_q[$];
    logic [1:0] exp_v;

    poly_mult_arbiter #(
        .RAMWIDTH(RAMWIDTH), .M(M), .LOG_MAX_WEIGHT(LOG_MAX_WEIGHT), .RA_W(RA_W)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .busy(busy),
        .r_start(r_start), .r_loc_in(r_loc_in), .r_weight(r_weight),
        .r_mux_word_0(r_mux_word_0), .r_mux_word_1(r_mux_word_1),
        .r_rd_dout(r_rd_dout), .r_addr_result(r_addr_result),
        .r_add_wr_en(r_add_wr_en), .r_add_addr(r_add_addr), .r_add_in(r_add_in),
        .r_valid(r_valid), .drop_err(drop_err),
        .pm_start(pm_start), .pm_loc_in(pm_loc_in), .pm_weight(pm_weight),
        .pm_mux_word_0(pm_mux_word_0), .pm_mux_word_1(pm_mux_word_1),
        .pm_rd_dout(pm_rd_dout), .pm_addr_result(pm_addr_result),
        .pm_add_wr_en(pm_add_wr_en), .pm_add_addr(pm_add_addr),
        .pm_add_in(pm_add_in), .pm_valid(pm_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        #1;
        n_chk++; if (gnt !== 2'b00) $display("FAIL reset_gnt: got %b want 00", gnt); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (drop_err !== 1'b0) $display("FAIL reset_drop_err: got %b want 0", drop_err); else n_pass++;
        n_chk++; if (pm_start !== 1'b0) $display("FAIL reset_pm_start: got %b want 0", pm_start); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_single();
        req = 2'b01;
        #1;
        n_chk++; if (gnt !== 2'b00) $display("FAIL grant_latency: got %b want 00", gnt); else n_pass++;
        tick();
        #1;
        n_chk++; if (gnt !== 2'b01) $display("FAIL grant_single: got %b want 01", gnt); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL busy_own: got %b want 1", busy); else n_pass++;
        r_start = 2'b01;
        #1;
        n_chk++; if (pm_start !== 1'b1) $display("FAIL pm_start_same_cycle: got %b want 1", pm_start); else n_pass++;
        sb_q.push_back(2'b01);
        tick();
        r_start = 2'b00;
        tick();
        tick();
        pm_valid = 1'b1;
        #1;
        n_chk++;
        if (sb_q.size() == 0) $display("FAIL r_valid_owner0: got %b want <empty scoreboard>", r_valid);
        else begin
            exp_v = sb_q.pop_front();
            if (r_valid !== exp_v) $display("FAIL r_valid_owner0: got %b want %b", r_valid, exp_v); else n_pass++;
        end
        tick();
        pm_valid = 1'b0;
        req = 2'b00;
        tick();
        #1;
        n_chk++; if (gnt !== 2'b00) $display("FAIL gap_after_release: got %b want 00", gnt); else n_pass++;
        n_chk++; if (drop_err !== 1'b0) $display("FAIL owner_start_no_err: got %b want 0", drop_err); else n_pass++;
        tick();
    endtask

    task automatic test_alternation();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 2'b11;
        tick();
        #1;
        n_chk++; if (gnt !== 2'b01) $display("FAIL tie_from_reset: got %b want 01", gnt); else n_pass++;
        req = 2'b10;
        r_mux_word_0 = {RAMWIDTH{2'b01}};
        r_addr_result = {2{9'h155}};
        tick();
        #1;
        n_chk++; if (gnt !== 2'b00) $display("FAIL gap_gnt: got %b want 00", gnt); else n_pass++;
        n_chk++; if (pm_mux_word_0 !== '0) $display("FAIL gap_pm_word: got %h want 0", pm_mux_word_0); else n_pass++;
        n_chk++; if (pm_addr_result !== '0) $display("FAIL gap_pm_addr: got %h want 0", pm_addr_result); else n_pass++;
        tick();
        #1;
        n_chk++; if (gnt !== 2'b00) $display("FAIL idle_gnt: got %b want 00", gnt); else n_pass++;
        tick();
        #1;
        n_chk++; if (gnt !== 2'b10) $display("FAIL handoff_to_1: got %b want 10", gnt); else n_pass++;
        req = 2'b01;
        tick();
        req = 2'b11;
        tick();
        tick();
        #1;
        n_chk++; if (gnt !== 2'b01) $display("FAIL alternate_to_0: got %b want 01", gnt); else n_pass++;
        req = 2'b10;
        tick();
        req = 2'b11;
        tick();
        tick();
        #1;
        n_chk++; if (gnt !== 2'b10) $display("FAIL alternate_to_1: got %b want 10", gnt); else n_pass++;
        req = 2'b00;
        r_mux_word_0 = '0;
        r_addr_result = '0;
        tick();
        tick();
    endtask

    task automatic test_drain();
        req = 2'b10;
        tick();
        #1;
        n_chk++; if (gnt !== 2'b10) $display("FAIL drain_grant: got %b want 10", gnt); else n_pass++;
        r_start = 2'b10;
        sb_q.push_back(2'b10);
        tick();
        r_start = 2'b00;
        repeat (4) tick();
        req = 2'b00;
        tick();
        #1;
        n_chk++; if (gnt !== 2'b10) $display("FAIL drain_gnt_held: got %b want 10", gnt); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL drain_busy: got %b want 1", busy); else n_pass++;
        r_start = 2'b10;
        #1;
        n_chk++; if (pm_start !== 1'b0) $display("FAIL start_blocked_drain: got %b want 0", pm_start); else n_pass++;
        tick();
        r_start = 2'b00;
        tick();
        #1;
        n_chk++; if (gnt !== 2'b10) $display("FAIL drain_still: got %b want 10", gnt); else n_pass++;
        pm_valid = 1'b1;
        #1;
        n_chk++;
        if (sb_q.size() == 0) $display("FAIL r_valid_drain: got %b want <empty scoreboard>", r_valid);
        else begin
            exp_v = sb_q.pop_front();
            if (r_valid !== exp_v) $display("FAIL r_valid_drain: got %b want %b", r_valid, exp_v); else n_pass++;
        end
        tick();
        pm_valid = 1'b0;
        #1;
        n_chk++; if (gnt !== 2'b00) $display("FAIL gap_after_drain: got %b want 00", gnt); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL gap_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (drop_err !== 1'b0) $display("FAIL drain_no_err: got %b want 0", drop_err); else n_pass++;
        tick();
    endtask

    task automatic test_drop_err();
        req = 2'b01;
        tick();
        #1;
        n_chk++; if (gnt !== 2'b01) $display("FAIL err_grant: got %b want 01", gnt); else n_pass++;
        r_start = 2'b10;
        #1;
        n_chk++; if (pm_start !== 1'b0) $display("FAIL nonowner_start_blocked: got %b want 0", pm_start); else n_pass++;
        tick();
        r_start = 2'b00;
        #1;
        n_chk++; if (drop_err !== 1'b1) $display("FAIL drop_err_set: got %b want 1", drop_err); else n_pass++;
        repeat (3) tick();
        req = 2'b00;
        tick();
        tick();
        #1;
        n_chk++; if (drop_err !== 1'b1) $display("FAIL drop_err_sticky: got %b want 1", drop_err); else n_pass++;
    endtask

    task automatic test_reset_drain();
        pm_valid = 1'b1;
        #1;
        n_chk++; if (r_valid !== 2'b00) $display("FAIL valid_no_owner: got %b want 00", r_valid); else n_pass++;
        tick();
        pm_valid = 1'b0;
        req = 2'b01;
        tick();
        r_start = 2'b01;
        tick();
        r_start = 2'b00;
        req = 2'b00;
        tick();
        #1;
        n_chk++; if ({gnt, busy} !== 3'b011) $display("FAIL drain_entered: got gnt=%b busy=%b want gnt=01 busy=1", gnt, busy); else n_pass++;
        rst = 1'b1;
        r_mux_word_0 = {2*RAMWIDTH{1'b1}};
        r_start = 2'b01;
        tick();
        #1;
        n_chk++; if (gnt !== 2'b00) $display("FAIL rst_drain_gnt: got %b want 00", gnt); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_drain_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if ({pm_start, pm_mux_word_0} !== '0) $display("FAIL rst_drain_pm: got start=%b word=%h want 0", pm_start, pm_mux_word_0); else n_pass++;
        n_chk++; if (drop_err !== 1'b0) $display("FAIL rst_clears_err: got %b want 0", drop_err); else n_pass++;
        rst = 1'b0;
        r_start = 2'b00;
        r_mux_word_0 = '0;
        req = 2'b11;
        tick();
        #1;
        n_chk++; if (gnt !== 2'b01) $display("FAIL tie_after_reset: got %b want 01", gnt); else n_pass++;
        req = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_mux();
        r_mux_word_0  = {{16{8'h5A}}, {16{8'hA5}}};
        r_mux_word_1  = {{4{32'hCAFEF00D}}, {4{32'h01234567}}};
        r_addr_result = {9'h1AA, 9'd7};
        r_loc_in      = {16'hBEEF, 16'h1234};
        r_weight      = {9'h0F3, 9'h10C};
        r_add_addr    = {9'h0C3, 9'h03C};
        r_add_in      = {{8{16'h9999}}, {8{16'h6666}}};
        r_rd_dout     = 2'b10;
        r_add_wr_en   = 2'b10;
        req = 2'b01;
        tick();
        #1;
        n_chk++; if (pm_mux_word_0 !== {16{8'hA5}}) $display("FAIL mux0_word0: got %h want a5..a5", pm_mux_word_0); else n_pass++;
        n_chk++; if (pm_addr_result !== 9'd7) $display("FAIL mux0_addr_result: got %h want 007", pm_addr_result); else n_pass++;
        n_chk++; if ({pm_loc_in, pm_weight, pm_add_addr} !== {16'h1234, 9'h10C, 9'h03C}) $display("FAIL mux0_ctrl: got %h/%h/%h want 1234/10c/03c", pm_loc_in, pm_weight, pm_add_addr); else n_pass++;
        n_chk++; if ({pm_rd_dout, pm_add_wr_en} !== 2'b00) $display("FAIL mux0_bits: got %b want 00", {pm_rd_dout, pm_add_wr_en}); else n_pass++;
        n_chk++; if ({pm_mux_word_1, pm_add_in} !== {{4{32'h01234567}}, {8{16'h6666}}}) $display("FAIL mux0_words: got %h %h", pm_mux_word_1, pm_add_in); else n_pass++;
        req = 2'b00;
        tick();
        tick();
        req = 2'b10;
        tick();
        #1;
        n_chk++; if (pm_mux_word_0 !== {16{8'h5A}}) $display("FAIL mux1_word0: got %h want 5a..5a", pm_mux_word_0); else n_pass++;
        n_chk++; if ({pm_loc_in, pm_weight, pm_addr_result, pm_add_addr} !== {16'hBEEF, 9'h0F3, 9'h1AA, 9'h0C3}) $display("FAIL mux1_ctrl: got %h/%h/%h/%h want beef/0f3/1aa/0c3", pm_loc_in, pm_weight, pm_addr_result, pm_add_addr); else n_pass++;
        n_chk++; if ({pm_rd_dout, pm_add_wr_en} !== 2'b11) $display("FAIL mux1_bits: got %b want 11", {pm_rd_dout, pm_add_wr_en}); else n_pass++;
        n_chk++; if ({pm_mux_word_1, pm_add_in} !== {{4{32'hCAFEF00D}}, {8{16'h9999}}}) $display("FAIL mux1_words: got %h %h", pm_mux_word_1, pm_add_in); else n_pass++;
        r_start = 2'b10;
        sb_q.push_back(2'b10);
        tick();
        r_start = 2'b00;
        pm_valid = 1'b1;
        #1;
        n_chk++;
        if (sb_q.size() == 0) $display("FAIL r_valid_owner1: got %b want <empty scoreboard>", r_valid);
        else begin
            exp_v = sb_q.pop_front();
            if (r_valid !== exp_v) $display("FAIL r_valid_owner1: got %b want %b", r_valid, exp_v); else n_pass++;
        end
        tick();
        pm_valid = 1'b0;
        req = 2'b00;
        tick();
        tick();
        n_chk++; if (sb_q.size() != 0) $display("FAIL scoreboard_drained: got %0d entries want 0", sb_q.size()); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        r_start = '0;
        r_loc_in = '0;
        r_weight = '0;
        r_mux_word_0 = '0;
        r_mux_word_1 = '0;
        r_rd_dout = '0;
        r_addr_result = '0;
        r_add_wr_en = '0;
        r_add_addr = '0;
        r_add_in = '0;
        pm_valid = 1'b0;
        test_reset();
        test_single();
        test_alternation();
        test_drain();
        test_drop_err();
        test_reset_drain();
        test_mux();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
